// File: rtl/fp_ctrl_pkg.sv
// Shared constants and types for the FP issue/scoreboard controller.
// Op encodings, FSM states and default timing live here.
package fp_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int OP_W  = 3;

    localparam int LAT_ADD_DEF = 3;
    localparam int LAT_MUL_DEF = 4;
    localparam int TIMEOUT_DEF = 32;

    typedef logic [REG_W-1:0] freg_t;
    typedef logic [OP_W-1:0]  fop_t;

    typedef enum logic [OP_W-1:0] {
        FP_ADD  = 3'd0,
        FP_SUB  = 3'd1,
        FP_MUL  = 3'd2,
        FP_DIV  = 3'd3,
        FP_SQRT = 3'd4
    } fp_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_WAIT_DONE,
        ST_WB
    } fp_state_t;

    function automatic logic is_var_op(input fop_t op);
        return (op == FP_DIV) || (op == FP_SQRT);
    endfunction

    function automatic logic is_mul_op(input fop_t op);
        return op == FP_MUL;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fp_issue_if.sv
// EX/D-stage and FPU signals seen by the FP issue controller.
// master = pipeline side, slave = controller side.
interface fp_issue_if;
    import fp_ctrl_pkg::*;

    logic  fp_valid_e;
    fop_t  fp_op_e;
    freg_t fp_rd_e;
    freg_t fp_rs1_d;
    freg_t fp_rs2_d;
    logic  fp_use_rs1_d;
    logic  fp_use_rs2_d;
    logic  fpu_done;

    logic  fpu_start;
    fop_t  fpu_op;
    logic  stall_fde;
    logic  fp_wb_en;
    freg_t fp_wb_rd;
    logic  busy;
    logic  timeout_err;

    modport master (
        output fp_valid_e,
        output fp_op_e,
        output fp_rd_e,
        output fp_rs1_d,
        output fp_rs2_d,
        output fp_use_rs1_d,
        output fp_use_rs2_d,
        output fpu_done,
        input  fpu_start,
        input  fpu_op,
        input  stall_fde,
        input  fp_wb_en,
        input  fp_wb_rd,
        input  busy,
        input  timeout_err
    );

    modport slave (
        input  fp_valid_e,
        input  fp_op_e,
        input  fp_rd_e,
        input  fp_rs1_d,
        input  fp_rs2_d,
        input  fp_use_rs1_d,
        input  fp_use_rs2_d,
        input  fpu_done,
        output fpu_start,
        output fpu_op,
        output stall_fde,
        output fp_wb_en,
        output fp_wb_rd,
        output busy,
        output timeout_err
    );

endinterface

// File: rtl/fp_lat_timer.sv
// Loadable down-counter with zero flag, shared between fixed-latency
// timing and the div/sqrt watchdog.
module fp_lat_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Saturates at zero so an idle dec never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fp_issue_ctrl.sv
// Single-outstanding FPU issue controller: starts ops from EX, tracks the
// pending destination, stalls F/D/E on hazards and pulses FP write-back.
module fp_issue_ctrl
    import fp_ctrl_pkg::*;
#(
    parameter int LAT_ADD = LAT_ADD_DEF,
    parameter int LAT_MUL = LAT_MUL_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    fp_issue_if.slave  io
);

    localparam int CNT_MAX = max3(LAT_ADD, LAT_MUL, TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    fp_state_t state;
    fp_state_t state_nx;

    freg_t pend_rd;
    logic  wb_en;
    freg_t wb_rd;
    logic  tmo_err;

    logic  accept;
    logic  pending;
    logic  tmo_hit;
    logic  raw_hazard;
    logic  rs1_hit;
    logic  rs2_hit;

    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    assign accept  = io.fp_valid_e &&
                     ((state == ST_IDLE) || (state == ST_WB));
    assign pending = (state != ST_IDLE);

    // WB still counts as pending: the regfile is not write-through.
    assign rs1_hit = io.fp_use_rs1_d &&
                     ((pending && (io.fp_rs1_d == pend_rd)) ||
                      (accept && (io.fp_rs1_d == io.fp_rd_e)));
    assign rs2_hit = io.fp_use_rs2_d &&
                     ((pending && (io.fp_rs2_d == pend_rd)) ||
                      (accept && (io.fp_rs2_d == io.fp_rd_e)));

    assign raw_hazard = rs1_hit || rs2_hit;

    // Fixed ops: BUSY spans LAT-1 cycles, so preload LAT-2.
    always_comb begin
        tmr_val = '0;
        unique case (1'b1)
            is_var_op(io.fp_op_e): tmr_val = CNT_W'(TIMEOUT - 1);
            is_mul_op(io.fp_op_e): tmr_val = CNT_W'(LAT_MUL - 2);
            default:               tmr_val = CNT_W'(LAT_ADD - 2);
        endcase
    end

    assign tmr_load = accept;
    assign tmr_dec  = (state == ST_BUSY) || (state == ST_WAIT_DONE);

    fp_lat_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nx = state;
        tmo_hit  = 1'b0;
        case (state)
            ST_IDLE, ST_WB: begin
                if (accept) begin
                    state_nx = is_var_op(io.fp_op_e) ? ST_WAIT_DONE
                                                     : ST_BUSY;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (tmr_zero) begin
                    state_nx = ST_WB;
                end
            end
            ST_WAIT_DONE: begin
                if (io.fpu_done) begin
                    state_nx = ST_WB;
                end else if (tmr_zero) begin
                    state_nx = ST_IDLE;
                    tmo_hit  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            pend_rd <= '0;
            wb_en   <= 1'b0;
            wb_rd   <= '0;
            tmo_err <= 1'b0;
        end else begin
            state <= state_nx;
            wb_en <= (state_nx == ST_WB);
            if (accept) begin
                pend_rd <= io.fp_rd_e;
            end
            if (state_nx == ST_WB) begin
                wb_rd <= pend_rd;
            end
            if (tmo_hit) begin
                tmo_err <= 1'b1;
            end
        end
    end

    assign io.fpu_start   = accept;
    assign io.fpu_op      = io.fp_op_e;
    assign io.stall_fde   = (io.fp_valid_e && !accept) || raw_hazard;
    assign io.fp_wb_en    = wb_en;
    assign io.fp_wb_rd    = wb_rd;
    assign io.busy        = pending;
    assign io.timeout_err = tmo_err;

endmodule

// File: doc/fp_issue_ctrl.md
Name: fp_issue_ctrl

Overview:
- Single-outstanding issue and scoreboard controller for a multi-cycle floating-point unit attached to the EX stage of the 5-stage RISC-V pipeline.
- Starts the FPU when an FP op reaches EX and tracks the pending destination register.
- Freezes F/D/E on structural or RAW hazards, then emits a one-cycle write-back pulse to the FP register file.
- Fixed-latency ops (add/sub/mul) are timed internally; variable ops (div/sqrt) complete on an FPU done handshake, guarded by a watchdog.

Parameters:
- LAT_ADD, 3, cycles from accept to write-back for add/sub (>=2)
- LAT_MUL, 4, cycles from accept to write-back for mul (>=2)
- TIMEOUT, 32, max cycles waiting for fpu_done before abort (>=2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- fp_valid_e  in  1  FP op present in EX (already qualified, not flushed)
- fp_op_e  in  3  0 add, 1 sub, 2 mul, 3 div, 4 sqrt, 5-7 reserved
- fp_rd_e  in  5  FP destination of EX op
- fp_rs1_d  in  5  FP source 1 of D-stage instruction
- fp_rs2_d  in  5  FP source 2 of D-stage instruction
- fp_use_rs1_d  in  1  D instruction reads fp_rs1_d
- fp_use_rs2_d  in  1  D instruction reads fp_rs2_d
- fpu_done  in  1  FPU result valid (div/sqrt only)
- fpu_start  out  1  combinational start pulse, equals accept
- fpu_op  out  3  combinational, equals fp_op_e
- stall_fde  out  1  hold F, D, E stage registers
- fp_wb_en  out  1  registered one-cycle FP regfile write enable
- fp_wb_rd  out  5  registered write-back register index
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- States: IDLE, BUSY (fixed latency), WAIT_DONE (div/sqrt), WB (write-back cycle).
- accept = fp_valid_e & (state==IDLE | state==WB). On accept, latch pend_rd <= fp_rd_e.
  - op 2: load counter for LAT_MUL, go to BUSY.
  - op 0/1/5/6/7: load counter for LAT_ADD, go to BUSY. Reserved ops are timed as add.
  - op 3/4: clear watchdog, go to WAIT_DONE.
- Fixed latency: accept in cycle t gives fp_wb_en=1 in cycle t+LAT exactly (state WB in that cycle).
- Variable latency: fpu_done high in cycle u while in WAIT_DONE gives WB in cycle u+1. fpu_done is ignored in every other state.
- Watchdog: after TIMEOUT consecutive WAIT_DONE cycles without fpu_done, go to IDLE with no write-back and set timeout_err=1. timeout_err clears only on reset.
- WB lasts one cycle: fp_wb_en=1, fp_wb_rd=pend_rd. The next state is IDLE, or the new op's state if accept occurs in the same cycle (back-to-back issue).
- pending = state in {BUSY, WAIT_DONE, WB}. The FP regfile is not write-through, so WB still counts as pending.
- raw_hazard = D reads (use flag set) a register equal to either:
  - pend_rd while pending, or
  - fp_rd_e while accept is asserted (covers the op leaving EX this cycle).
- stall_fde = (fp_valid_e & ~accept) | raw_hazard. While stalled, the EX op stays in EX and is re-presented, so it is accepted once the controller frees.
- fpu_start asserts for exactly one cycle per accepted op: accept implies the EX register advances next cycle.
- Register x0 gets no special treatment: FP f0 is a real register.
- Reset (async, any state, including mid-op): state IDLE, counters 0, pend_rd 0, fp_wb_en 0, fp_wb_rd 0, timeout_err 0. Combinational outputs follow from these values. An in-flight op is dropped; a late fpu_done is ignored.

Decomposition:
- Shared package fp_ctrl_pkg holds:
  - op encodings (FP_ADD..FP_SQRT)
  - state encoding
  - default latency and timeout constants
  - register-index width (5)
- One sub-module, fp_lat_timer: loadable down-counter with zero flag, wide enough for max(LAT_MUL, TIMEOUT). It is instantiated once and shared, since fixed-latency timing and the watchdog are never active together.

Test Plan:
- Reset low mid-BUSY (after add accept) -> all registered outputs 0 immediately, busy=0; fpu_done pulse afterwards produces no fp_wb_en.
- Add f3 accepted at cycle 10 -> fpu_start=1 in cycle 10 only; fp_wb_en=1 with fp_wb_rd=3 in cycle 13 only; busy cycles 11-13.
- Mul f5, then second FP op in EX at cycle 11 -> stall_fde=1 cycles 11-13; second op accepted in cycle 14 (WB cycle); fp_wb_rd=5 in cycle 14.
- Div f7, D reads f7 via rs2 -> stall_fde held until fpu_done at cycle u; wb in u+1; stall drops in u+2. Same sequence with use_rs2_d=0 -> no stall.
- Sqrt with fpu_done never asserted -> after 32 WAIT_DONE cycles state IDLE, timeout_err=1 stays set, fp_wb_en never high.
- Accept of add f2 while D reads f2 in the same cycle -> stall_fde=1 in the accept cycle (EX-rd hazard path).
